// File: rtl/store_unit.sv
// Store execution unit: forms the effective address, lane-aligns data and byte
// enables, and writes one or two beats to data memory over a valid/ready port.
module store_unit #(
  parameter int unsigned XLEN           = 32,
  parameter bit          MISALIGN_SPLIT = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_funct3,
  input  logic [XLEN-1:0]   req_base,
  input  logic [11:0]       req_imm,
  input  logic [XLEN-1:0]   req_data,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_be,
  output logic              done,
  output logic              err,
  output logic [XLEN-1:0]   err_addr
);

  localparam int unsigned NB    = XLEN / 8;
  localparam int unsigned OB    = $clog2(NB);
  localparam int unsigned NB2   = 2 * NB;
  localparam int unsigned XLEN2 = 2 * XLEN;
  localparam bit          SD_OK = (XLEN == 64);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, ERR} state_t;

  state_t state_q, state_n;

  logic [XLEN-1:0]  ea_c, dmask_c;
  logic [OB-1:0]    off_c;
  logic [3:0]       sz_c;
  logic [NB2-1:0]   be_wide_c;
  logic [XLEN2-1:0] wd_wide_c;
  logic             illegal_c, misal_c, cross_c, reject_c;

  logic             req_ready_n, mem_valid_n, done_n, err_n;
  logic [XLEN-1:0]  mem_addr_n, mem_wdata_n, err_addr_n;
  logic [NB-1:0]    mem_be_n;

  logic [XLEN-1:0]  ea_q, ea_n;
  logic             cross_q, cross_n;
  logic [NB-1:0]    hi_be_q, hi_be_n;
  logic [XLEN-1:0]  hi_wdata_q, hi_wdata_n;

  // Request decode: the upper half of the double-width shifts is the second beat.
  always_comb begin
    ea_c      = req_base + {{(XLEN-12){req_imm[11]}}, req_imm};
    off_c     = ea_c[OB-1:0];
    sz_c      = 4'd1 << req_funct3[1:0];
    dmask_c   = {XLEN{1'b1}} >> (XLEN - 8 * sz_c);
    be_wide_c = ((NB2'(1) << sz_c) - NB2'(1)) << off_c;
    wd_wide_c = {XLEN'(0), req_data & dmask_c} << {off_c, 3'b000};
    illegal_c = req_funct3[2] | ((req_funct3[1:0] == 2'b11) & ~SD_OK);
    misal_c   = (off_c & OB'(sz_c - 4'd1)) != '0;
    cross_c   = (5'(off_c) + 5'(sz_c)) > 5'(NB);
    reject_c  = illegal_c | (misal_c & ~MISALIGN_SPLIT);
  end

  // Next-state and next-output logic; every output is registered from here.
  always_comb begin
    state_n     = state_q;
    req_ready_n = req_ready;
    mem_valid_n = mem_valid;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    mem_be_n    = mem_be;
    done_n      = 1'b0;
    err_n       = 1'b0;
    err_addr_n  = err_addr;
    ea_n        = ea_q;
    cross_n     = cross_q;
    hi_be_n     = hi_be_q;
    hi_wdata_n  = hi_wdata_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          req_ready_n = 1'b0;
          ea_n        = ea_c;
          if (reject_c) begin
            state_n = ERR;
          end else begin
            state_n     = BEAT0;
            mem_valid_n = 1'b1;
            mem_addr_n  = {ea_c[XLEN-1:OB], OB'(0)};
            mem_be_n    = be_wide_c[NB-1:0];
            mem_wdata_n = wd_wide_c[XLEN-1:0];
            cross_n     = cross_c;
            hi_be_n     = be_wide_c[NB2-1:NB];
            hi_wdata_n  = wd_wide_c[XLEN2-1:XLEN];
          end
        end
      end
      BEAT0: begin
        if (mem_ready) begin
          if (cross_q) begin
            state_n     = BEAT1;
            mem_addr_n  = mem_addr + XLEN'(NB);
            mem_be_n    = hi_be_q;
            mem_wdata_n = hi_wdata_q;
          end else begin
            state_n     = IDLE;
            mem_valid_n = 1'b0;
            req_ready_n = 1'b1;
            done_n      = 1'b1;
          end
        end
      end
      BEAT1: begin
        if (mem_ready) begin
          state_n     = IDLE;
          mem_valid_n = 1'b0;
          req_ready_n = 1'b1;
          done_n      = 1'b1;
        end
      end
      ERR: begin
        state_n     = IDLE;
        req_ready_n = 1'b1;
        err_n       = 1'b1;
        err_addr_n  = ea_q;
      end
      default: begin
        state_n     = IDLE;
        req_ready_n = 1'b1;
        mem_valid_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      req_ready  <= 1'b1;
      mem_valid  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_addr   <= '0;
      ea_q       <= '0;
      cross_q    <= 1'b0;
      hi_be_q    <= '0;
      hi_wdata_q <= '0;
    end else begin
      state_q    <= state_n;
      req_ready  <= req_ready_n;
      mem_valid  <= mem_valid_n;
      mem_addr   <= mem_addr_n;
      mem_wdata  <= mem_wdata_n;
      mem_be     <= mem_be_n;
      done       <= done_n;
      err        <= err_n;
      err_addr   <= err_addr_n;
      ea_q       <= ea_n;
      cross_q    <= cross_n;
      hi_be_q    <= hi_be_n;
      hi_wdata_q <= hi_wdata_n;
    end
  end

endmodule

// File: tb/tb_store_unit.sv
// Directed bench for store_unit: XLEN=32 split, XLEN=32 reject, XLEN=64 split.
module tb_store_unit;

  logic clk, rst_n;
  int   checks   = 0;
  int   failures = 0;

  // Instance A: XLEN=32, MISALIGN_SPLIT=1
  logic        a_req_valid, a_req_ready, a_mem_valid, a_mem_ready, a_done, a_err;
  logic [2:0]  a_f3;
  logic [11:0] a_imm;
  logic [31:0] a_base, a_data, a_mem_addr, a_mem_wdata, a_err_addr;
  logic [3:0]  a_mem_be;

  // Instance B: XLEN=32, MISALIGN_SPLIT=0
  logic        b_req_valid, b_req_ready, b_mem_valid, b_mem_ready, b_done, b_err;
  logic [2:0]  b_f3;
  logic [11:0] b_imm;
  logic [31:0] b_base, b_data, b_mem_addr, b_mem_wdata, b_err_addr;
  logic [3:0]  b_mem_be;

  // Instance C: XLEN=64, MISALIGN_SPLIT=1
  logic        c_req_valid, c_req_ready, c_mem_valid, c_mem_ready, c_done, c_err;
  logic [2:0]  c_f3;
  logic [11:0] c_imm;
  logic [63:0] c_base, c_data, c_mem_addr, c_mem_wdata, c_err_addr;
  logic [7:0]  c_mem_be;

  store_unit #(.XLEN(32), .MISALIGN_SPLIT(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_funct3(a_f3), .req_base(a_base), .req_imm(a_imm), .req_data(a_data),
    .mem_valid(a_mem_valid), .mem_ready(a_mem_ready), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_be(a_mem_be), .done(a_done), .err(a_err),
    .err_addr(a_err_addr));

  store_unit #(.XLEN(32), .MISALIGN_SPLIT(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_funct3(b_f3), .req_base(b_base), .req_imm(b_imm), .req_data(b_data),
    .mem_valid(b_mem_valid), .mem_ready(b_mem_ready), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_be(b_mem_be), .done(b_done), .err(b_err),
    .err_addr(b_err_addr));

  store_unit #(.XLEN(64), .MISALIGN_SPLIT(1'b1)) u_c (
    .clk(clk), .rst_n(rst_n), .req_valid(c_req_valid), .req_ready(c_req_ready),
    .req_funct3(c_f3), .req_base(c_base), .req_imm(c_imm), .req_data(c_data),
    .mem_valid(c_mem_valid), .mem_ready(c_mem_ready), .mem_addr(c_mem_addr),
    .mem_wdata(c_mem_wdata), .mem_be(c_mem_be), .done(c_done), .err(c_err),
    .err_addr(c_err_addr));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_req(input logic [2:0] f3, input logic [31:0] base,
                       input logic [11:0] imm, input logic [31:0] data);
    a_f3 = f3; a_base = base; a_imm = imm; a_data = data; a_req_valid = 1'b1;
    step();
    a_req_valid = 1'b0;
  endtask

  task automatic b_req(input logic [2:0] f3, input logic [31:0] base,
                       input logic [11:0] imm, input logic [31:0] data);
    b_f3 = f3; b_base = base; b_imm = imm; b_data = data; b_req_valid = 1'b1;
    step();
    b_req_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    a_req_valid = 1'b0; a_f3 = '0; a_base = '0; a_imm = '0; a_data = '0; a_mem_ready = 1'b1;
    b_req_valid = 1'b0; b_f3 = '0; b_base = '0; b_imm = '0; b_data = '0; b_mem_ready = 1'b1;
    c_req_valid = 1'b0; c_f3 = '0; c_base = '0; c_imm = '0; c_data = '0; c_mem_ready = 1'b1;

    // Reset state
    #12;
    chk("rst_ready",    a_req_ready, 1);
    chk("rst_valid",    a_mem_valid, 0);
    chk("rst_done",     a_done, 0);
    chk("rst_err",      a_err, 0);
    chk("rst_addr",     a_mem_addr, 0);
    chk("rst_wdata",    a_mem_wdata, 0);
    chk("rst_be",       a_mem_be, 0);
    chk("rst_err_addr", a_err_addr, 0);
    chk("rst_c_ready",  c_req_ready, 1);
    rst_n = 1'b1;
    step();

    // Aligned SW, single beat
    a_req(3'd2, 32'h1000, 12'h004, 32'hDEADBEEF);
    chk("sw_valid", a_mem_valid, 1);
    chk("sw_ready", a_req_ready, 0);
    chk("sw_addr",  a_mem_addr, 32'h1004);
    chk("sw_be",    a_mem_be, 4'b1111);
    chk("sw_wdata", a_mem_wdata, 32'hDEADBEEF);
    step();
    chk("sw_done",  a_done, 1);
    chk("sw_idle",  a_mem_valid, 0);
    chk("sw_rdy1",  a_req_ready, 1);

    // SB with negative immediate, issued back-to-back
    a_req(3'd0, 32'h1003, 12'hFFF, 32'h123456EF);
    chk("sw_done_pulse", a_done, 0);
    chk("sb_addr",  a_mem_addr, 32'h1000);
    chk("sb_be",    a_mem_be, 4'b0100);
    chk("sb_wdata", a_mem_wdata, 32'h00EF0000);
    step();
    chk("sb_done",  a_done, 1);

    // Misaligned SH that stays inside one lane group
    a_req(3'd1, 32'h3001, 12'h000, 32'hFFFFABCD);
    chk("sh1_addr",  a_mem_addr, 32'h3000);
    chk("sh1_be",    a_mem_be, 4'b0110);
    chk("sh1_wdata", a_mem_wdata, 32'h00ABCD00);
    step();
    chk("sh1_done",  a_done, 1);
    chk("sh1_one_beat", a_mem_valid, 0);

    // Split SW at 0x1002 with 3 cycles of backpressure on beat0
    a_mem_ready = 1'b0;
    a_req(3'd2, 32'h1000, 12'h002, 32'hDEADBEEF);
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid", a_mem_valid, 1);
      chk("bp_addr",  a_mem_addr, 32'h1000);
      chk("bp_be",    a_mem_be, 4'b1100);
      chk("bp_wdata", a_mem_wdata, 32'hBEEF0000);
      chk("bp_ready", a_req_ready, 0);
      chk("bp_done",  a_done, 0);
      if (i < 2) step();
    end
    a_mem_ready = 1'b1;
    step();
    chk("b1_valid", a_mem_valid, 1);
    chk("b1_addr",  a_mem_addr, 32'h1004);
    chk("b1_be",    a_mem_be, 4'b0011);
    chk("b1_wdata", a_mem_wdata, 32'h0000DEAD);
    chk("b1_done",  a_done, 0);
    step();
    chk("split_done",  a_done, 1);
    chk("split_idle",  a_mem_valid, 0);
    chk("split_ready", a_req_ready, 1);
    step();
    chk("split_done_once", a_done, 0);

    // Split SW wrapping past the top of the address space
    a_req(3'd2, 32'hFFFFFFFE, 12'h000, 32'h11223344);
    chk("wr0_addr",  a_mem_addr, 32'hFFFFFFFC);
    chk("wr0_wdata", a_mem_wdata, 32'h33440000);
    step();
    chk("wr1_addr",  a_mem_addr, 32'h00000000);
    chk("wr1_be",    a_mem_be, 4'b0011);
    chk("wr1_wdata", a_mem_wdata, 32'h00001122);
    step();
    chk("wr_done", a_done, 1);

    // SD on XLEN=32 is illegal
    a_req(3'd3, 32'h2000, 12'h000, 32'h0);
    chk("f3_errstate_valid", a_mem_valid, 0);
    chk("f3_errstate_err",   a_err, 0);
    step();
    chk("f3_err",      a_err, 1);
    chk("f3_err_addr", a_err_addr, 32'h2000);
    chk("f3_no_done",  a_done, 0);
    chk("f3_no_beat",  a_mem_valid, 0);
    chk("f3_ready",    a_req_ready, 1);
    step();
    chk("f3_err_pulse", a_err, 0);
    chk("f3_err_hold",  a_err_addr, 32'h2000);

    // Reject mode: misaligned SH errors, aligned SH goes through
    b_req(3'd1, 32'h2000, 12'h001, 32'h5678);
    chk("rej_no_beat0", b_mem_valid, 0);
    step();
    chk("rej_err",      b_err, 1);
    chk("rej_err_addr", b_err_addr, 32'h2001);
    chk("rej_no_done",  b_done, 0);
    chk("rej_no_beat1", b_mem_valid, 0);
    b_req(3'd1, 32'h2002, 12'h000, 32'hAAAA5678);
    chk("rej_sh_be",    b_mem_be, 4'b1100);
    chk("rej_sh_wdata", b_mem_wdata, 32'h56780000);
    step();
    chk("rej_sh_done",  b_done, 1);
    chk("rej_sh_noerr", b_err, 0);

    // Reset while in beat1 abandons the store
    a_req(3'd2, 32'h1000, 12'h002, 32'hCAFEF00D);
    step();
    chk("rb_in_beat1", a_mem_addr, 32'h1004);
    rst_n = 1'b0;
    #1;
    chk("rb_valid_async", a_mem_valid, 0);
    chk("rb_ready_async", a_req_ready, 1);
    #2;
    rst_n = 1'b1;
    step();
    chk("rb_no_beat", a_mem_valid, 0);
    chk("rb_no_done", a_done, 0);
    chk("rb_ready",   a_req_ready, 1);
    step();
    chk("rb_still_idle", a_mem_valid, 0);

    // XLEN=64 SD at 0x0FFC splits into two beats
    c_f3 = 3'd3; c_base = 64'h0FFC; c_imm = 12'h000; c_data = 64'h0123456789ABCDEF;
    c_req_valid = 1'b1;
    step();
    c_req_valid = 1'b0;
    chk("sd0_valid", c_mem_valid, 1);
    chk("sd0_addr",  c_mem_addr, 64'h0FF8);
    chk("sd0_be",    c_mem_be, 8'hF0);
    chk("sd0_wdata", c_mem_wdata, 64'h89ABCDEF00000000);
    step();
    chk("sd1_addr",  c_mem_addr, 64'h1000);
    chk("sd1_be",    c_mem_be, 8'h0F);
    chk("sd1_wdata", c_mem_wdata, 64'h0000000001234567);
    chk("sd1_done",  c_done, 0);
    step();
    chk("sd_done",   c_done, 1);
    chk("sd_idle",   c_mem_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
